// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM address, IF/ID boundary, redirect/stall/squash control.
// Optional performance counters are built when FETCH_PERF_EN is defined; otherwise they read 0.
module fetch_stage #(
  parameter int unsigned     PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_data,
  input  logic            stall,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            flush_out,
  output logic [31:0]     instr_id,
  output logic [PC_W-1:0] pc_plus1_id,
  output logic            valid_id,
  output logic [1:0]      fetch_state,
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
);

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic [31:0]     instr;
    logic [PC_W-1:0] pc_plus1;
    logic            valid;
  } ifid_t;

  localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc_plus1: {PC_W{1'b0}}, valid: 1'b0};

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus1;
  ifid_t           ifid_q;

  assign pc_plus1    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  assign imem_addr   = pc_q;
  assign flush_out   = branch_taken;
  assign instr_id    = ifid_q.instr;
  assign pc_plus1_id = ifid_q.pc_plus1;
  assign valid_id    = ifid_q.valid;
  assign fetch_state = state_q;

  // Priority: taken branch > stall > jump > sequential. A branch overrides a
  // stall because the held instruction is on the wrong path anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ifid_q  <= BUBBLE;
    end else begin
      case (state_q)
        BOOT: begin
          state_q <= RUN;
          ifid_q  <= BUBBLE;
        end
        default: begin
          if (branch_taken) begin
            state_q <= RUN;
            pc_q    <= branch_target;
            ifid_q  <= BUBBLE;
          end else if (stall) begin
            // jump is dropped here; decode re-asserts it while the instr is held
            state_q <= HOLD;
          end else if (jump) begin
            state_q <= RUN;
            pc_q    <= jump_target;
            ifid_q  <= BUBBLE;
          end else begin
            state_q <= RUN;
            pc_q    <= pc_plus1;
            ifid_q  <= '{instr: imem_data, pc_plus1: pc_plus1, valid: 1'b1};
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic active;
  logic fetch_ev;
  logic squash_ev;

  assign active    = (state_q != BOOT);
  assign fetch_ev  = active & ~branch_taken & ~stall & ~jump;
  assign squash_ev = active & (branch_taken | (jump & ~stall));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (fetch_ev)         fetch_cnt <= fetch_cnt + 32'd1;
      if (active && stall)  stall_cnt <= stall_cnt + 32'd1;
      if (squash_ev)        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; ROM model returns word address + 100.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        jump;
  logic [31:0] jump_target;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        flush_out;
  logic [31:0] instr_id;
  logic [31:0] pc_plus1_id;
  logic        valid_id;
  logic [1:0]  fetch_state;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int errors = 0;
  int checks = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jump(jump), .jump_target(jump_target),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .flush_out(flush_out), .instr_id(instr_id), .pc_plus1_id(pc_plus1_id),
    .valid_id(valid_id), .fetch_state(fetch_state),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign imem_data = imem_addr + 32'd100;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 0; jump = 0; branch_taken = 0;
    jump_target = '0; branch_target = '0;
    #2;
    checks++; if (imem_addr !== 32'd0) begin errors++; $display("FAIL rst_addr got %0h want 0", imem_addr); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b want 0", valid_id); end
    checks++; if (instr_id !== 32'd0) begin errors++; $display("FAIL rst_instr got %0h want 0", instr_id); end
    checks++; if (pc_plus1_id !== 32'd0) begin errors++; $display("FAIL rst_pc1 got %0h want 0", pc_plus1_id); end
    checks++; if (fetch_state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", fetch_state); end
    checks++; if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'd0) begin errors++; $display("FAIL rst_cnt got %0h/%0h/%0h want 0", fetch_cnt, stall_cnt, flush_cnt); end
    branch_taken = 1'b1; #1;
    checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL rst_flush_hi got %0b want 1", flush_out); end
    branch_taken = 1'b0; #1;
    checks++; if (flush_out !== 1'b0) begin errors++; $display("FAIL rst_flush_lo got %0b want 0", flush_out); end
    step();
    checks++; if (fetch_state !== 2'd0 || imem_addr !== 32'd0) begin errors++; $display("FAIL rst_hold got state %0d addr %0h want 0/0", fetch_state, imem_addr); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    step(); // BOOT -> RUN
    checks++; if (fetch_state !== 2'd1 || valid_id !== 1'b0 || imem_addr !== 32'd0) begin errors++; $display("FAIL boot got state %0d valid %0b addr %0h want 1/0/0", fetch_state, valid_id, imem_addr); end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (instr_id !== 32'(100 + k) || pc_plus1_id !== 32'(k + 1) || valid_id !== 1'b1 || imem_addr !== 32'(k + 1)) begin
        errors++; $display("FAIL seq%0d got instr %0d pc1 %0d valid %0b addr %0d want %0d/%0d/1/%0d", k, instr_id, pc_plus1_id, valid_id, imem_addr, 100 + k, k + 1, k + 1);
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (instr_id !== 32'd101 || imem_addr !== 32'd2 || fetch_state !== 2'd2) begin
        errors++; $display("FAIL stall%0d got instr %0d addr %0d state %0d want 101/2/2", k, instr_id, imem_addr, fetch_state);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (instr_id !== 32'd102 || pc_plus1_id !== 32'd3 || imem_addr !== 32'd3 || fetch_state !== 2'd1) begin errors++; $display("FAIL stall_resume got instr %0d pc1 %0d addr %0d state %0d want 102/3/3/1", instr_id, pc_plus1_id, imem_addr, fetch_state); end
  endtask

  task automatic test_jump();
    jump = 1'b1; jump_target = 32'd40;
    step();
    jump = 1'b0;
    checks++; if (valid_id !== 1'b0 || imem_addr !== 32'd40 || instr_id !== 32'd0 || pc_plus1_id !== 32'd0) begin errors++; $display("FAIL jump_bubble got valid %0b addr %0d instr %0h pc1 %0h want 0/40/0/0", valid_id, imem_addr, instr_id, pc_plus1_id); end
    step();
    checks++; if (instr_id !== 32'd140 || pc_plus1_id !== 32'd41 || valid_id !== 1'b1) begin errors++; $display("FAIL jump_fetch got instr %0d pc1 %0d valid %0b want 140/41/1", instr_id, pc_plus1_id, valid_id); end
  endtask

  task automatic test_jump_stall();
    jump = 1'b1; jump_target = 32'd70; stall = 1'b1;
    step();
    checks++; if (instr_id !== 32'd140 || imem_addr !== 32'd41 || fetch_state !== 2'd2) begin errors++; $display("FAIL jstall_hold got instr %0d addr %0d state %0d want 140/41/2", instr_id, imem_addr, fetch_state); end
    stall = 1'b0;
    step();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'd70 || valid_id !== 1'b0 || fetch_state !== 2'd1) begin errors++; $display("FAIL jstall_take got addr %0d valid %0b state %0d want 70/0/1", imem_addr, valid_id, fetch_state); end
    step();
    checks++; if (instr_id !== 32'd170 || imem_addr !== 32'd71) begin errors++; $display("FAIL jstall_fetch got instr %0d addr %0d want 170/71", instr_id, imem_addr); end
  endtask

  task automatic test_branch();
    branch_taken = 1'b1; branch_target = 32'd8; stall = 1'b1; jump = 1'b1; jump_target = 32'd99;
    #1;
    checks++; if (flush_out !== 1'b1) begin errors++; $display("FAIL br_flush got %0b want 1", flush_out); end
    step();
    branch_taken = 1'b0; stall = 1'b0; jump = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'd8 || valid_id !== 1'b0 || fetch_state !== 2'd1 || flush_out !== 1'b0) begin errors++; $display("FAIL br_redirect got addr %0d valid %0b state %0d flush %0b want 8/0/1/0", imem_addr, valid_id, fetch_state, flush_out); end
    step();
    checks++; if (instr_id !== 32'd108 || imem_addr !== 32'd9) begin errors++; $display("FAIL br_fetch got instr %0d addr %0d want 108/9", instr_id, imem_addr); end
  endtask

  task automatic test_wrap();
    jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    step();
    jump = 1'b0;
    step();
    checks++; if (instr_id !== 32'd99 || pc_plus1_id !== 32'd0 || imem_addr !== 32'd0 || valid_id !== 1'b1) begin errors++; $display("FAIL wrap got instr %0d pc1 %0h addr %0h valid %0b want 99/0/0/1", instr_id, pc_plus1_id, imem_addr, valid_id); end
  endtask

  task automatic test_counters();
    logic [31:0] ef, es, efl;
    for (int k = 0; k < 3; k++) step();
    checks++; if (instr_id !== 32'd102 || imem_addr !== 32'd3) begin errors++; $display("FAIL cnt_seq got instr %0d addr %0d want 102/3", instr_id, imem_addr); end
    ef  = PERF ? 32'd10 : 32'd0;
    es  = PERF ? 32'd4  : 32'd0;
    efl = PERF ? 32'd4  : 32'd0;
    checks++; if (fetch_cnt !== ef) begin errors++; $display("FAIL fetch_cnt got %0d want %0d", fetch_cnt, ef); end
    checks++; if (stall_cnt !== es) begin errors++; $display("FAIL stall_cnt got %0d want %0d", stall_cnt, es); end
    checks++; if (flush_cnt !== efl) begin errors++; $display("FAIL flush_cnt got %0d want %0d", flush_cnt, efl); end
  endtask

  task automatic test_async_reset();
    logic [31:0] ef;
    jump = 1'b1; jump_target = 32'd57;
    step();
    jump = 1'b0;
    checks++; if (imem_addr !== 32'd57) begin errors++; $display("FAIL ar_pre got addr %0d want 57", imem_addr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'd0 || valid_id !== 1'b0 || fetch_state !== 2'd0) begin errors++; $display("FAIL ar_clear got addr %0d valid %0b state %0d want 0/0/0", imem_addr, valid_id, fetch_state); end
    checks++; if ({fetch_cnt, stall_cnt, flush_cnt} !== 96'd0) begin errors++; $display("FAIL ar_cnt got %0d/%0d/%0d want 0", fetch_cnt, stall_cnt, flush_cnt); end
    step();
    rst = 1'b0;
    jump = 1'b1; jump_target = 32'd20; // must be ignored in BOOT
    step();
    jump = 1'b0;
    checks++; if (fetch_state !== 2'd1 || imem_addr !== 32'd0 || valid_id !== 1'b0) begin errors++; $display("FAIL ar_boot got state %0d addr %0d valid %0b want 1/0/0", fetch_state, imem_addr, valid_id); end
    step();
    checks++; if (instr_id !== 32'd100 || imem_addr !== 32'd1 || valid_id !== 1'b1) begin errors++; $display("FAIL ar_fetch got instr %0d addr %0d valid %0b want 100/1/1", instr_id, imem_addr, valid_id); end
    ef = PERF ? 32'd1 : 32'd0;
    checks++; if (fetch_cnt !== ef) begin errors++; $display("FAIL ar_fetch_cnt got %0d want %0d", fetch_cnt, ef); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_jump_stall();
    test_branch();
    test_wrap();
    test_counters();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
